// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, sizing constants and grant helper for bus_arbiter_4
package bus_arb_pkg;

   localparam int NR_OF_REQUESTERS = 4;
   localparam int ID_WIDTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic logic [NR_OF_REQUESTERS-1:0] onehot(input logic [ID_WIDTH-1:0] id);
      return NR_OF_REQUESTERS'(1) << id;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin winner search starting just after the last owner
module rr_priority_picker
   import bus_arb_pkg::*;
(
   input  logic [NR_OF_REQUESTERS-1:0] Request,
   input  logic [ID_WIDTH-1:0]         LastId,
   output logic [ID_WIDTH-1:0]         WinnerId,
   output logic                        WinnerValid
);

   // Scan from the farthest candidate (LastId itself) to the nearest (LastId+1); the nearest hit overrides
   always_comb begin
      WinnerId = LastId;
      WinnerValid = 1'b0;
      for (int k = NR_OF_REQUESTERS; k >= 1; k--) begin
         if (Request[LastId + ID_WIDTH'(k)]) begin
            WinnerId = LastId + ID_WIDTH'(k);
            WinnerValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: 4-way round-robin bus arbiter with registered one-hot grant and 1-cycle turnaround gap; optional ownership timeout under ARB_TIMEOUT_EN
module bus_arbiter_4
   import bus_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        GlobalClock,
   input  logic                        Reset,
   input  logic                        ClockEnable,
   input  logic [NR_OF_REQUESTERS-1:0] Request,
   output logic [NR_OF_REQUESTERS-1:0] Grant,
   output logic                        GrantValid,
   output logic [ID_WIDTH-1:0]         GrantId,
   output logic                        BusIdle,
   output logic                        Timeout
);

   state_t                      state, next_state;
   logic [NR_OF_REQUESTERS-1:0] grant_q, next_grant;
   logic [ID_WIDTH-1:0]         grant_id, next_id;
   logic [ID_WIDTH-1:0]         last_id, next_last;
   logic [ID_WIDTH-1:0]         winner_id;
   logic                        winner_valid;
   logic                        expire;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 2..255");
   end

   rr_priority_picker u_picker (
      .Request     (Request),
      .LastId      (last_id),
      .WinnerId    (winner_id),
      .WinnerValid (winner_valid)
   );

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic       timeout_q;

   assign expire  = (state == GRANT) && (hold_cnt == 8'(TIMEOUT_CYCLES - 1)) && Request[grant_id];
   assign Timeout = timeout_q;

   // Hold counter is zero outside GRANT so it starts clean on every entry; Timeout flags the revoking edge
   always_ff @(posedge GlobalClock or posedge Reset)
      if (Reset) begin
         hold_cnt  <= 8'd0;
         timeout_q <= 1'b0;
      end else if (ClockEnable) begin
         hold_cnt  <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
         timeout_q <= expire;
      end
`else
   assign expire  = 1'b0;
   assign Timeout = 1'b0;
`endif

   // Next state: hold the owner until it releases (or expires); IDLE and GAP both arbitrate from last_id
   always_comb begin
      next_state = state;
      next_grant = grant_q;
      next_id    = grant_id;
      next_last  = last_id;
      case (state)
         GRANT: begin
            if (!Request[grant_id] || expire) begin
               next_state = GAP;
               next_grant = '0;
               next_last  = grant_id;
            end
         end
         default: begin
            next_state = winner_valid ? GRANT : IDLE;
            next_grant = winner_valid ? onehot(winner_id) : '0;
            next_id    = winner_valid ? winner_id : grant_id;
         end
      endcase
   end

   // State, grant and rotation pointer registers; reset leaves requester 0 first in line
   always_ff @(posedge GlobalClock or posedge Reset)
      if (Reset) begin
         state    <= IDLE;
         grant_q  <= '0;
         grant_id <= '0;
         last_id  <= ID_WIDTH'(NR_OF_REQUESTERS - 1);
      end else if (ClockEnable) begin
         state    <= next_state;
         grant_q  <= next_grant;
         grant_id <= next_id;
         last_id  <= next_last;
      end

   assign Grant      = grant_q;
   assign GrantValid = |grant_q;
   assign GrantId    = grant_id;
   assign BusIdle    = ~(|Request) & ~GrantValid;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// tb_bus_arbiter_4: directed plus randomized checks of bus_arbiter_4 against an owner/rotation reference model
module tb_bus_arbiter_4;

   localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic       GlobalClock, Reset, ClockEnable;
   logic [3:0] Request, Grant;
   logic       GrantValid, BusIdle, Timeout;
   logic [1:0] GrantId;

   int checks = 0;
   int fails = 0;

   int m_owner, m_last, m_gid, m_held;
   bit m_to;

   bus_arbiter_4 #(.TIMEOUT_CYCLES(TMO)) dut (
      .GlobalClock (GlobalClock),
      .Reset       (Reset),
      .ClockEnable (ClockEnable),
      .Request     (Request),
      .Grant       (Grant),
      .GrantValid  (GrantValid),
      .GrantId     (GrantId),
      .BusIdle     (BusIdle),
      .Timeout     (Timeout)
   );

   initial GlobalClock = 1'b0;
   always #5 GlobalClock = ~GlobalClock;

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_gid   = 0;
      m_held  = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_edge();
      bit found;
      if (!ClockEnable) return;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         if (!Request[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
         end else if (TMO_ON && m_held == TMO - 1) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 1'b1;
         end else m_held++;
      end else begin
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            if (!found && Request[(m_last + k) % 4]) begin
               found   = 1'b1;
               m_owner = (m_last + k) % 4;
               m_gid   = m_owner;
               m_held  = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check(input string tag);
      logic [3:0] eg;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      chk({tag, ".grant"}, 8'(Grant), 8'(eg));
      chk({tag, ".valid"}, 8'(GrantValid), 8'(m_owner >= 0));
      chk({tag, ".id"}, 8'(GrantId), 8'(m_gid));
      chk({tag, ".idle"}, 8'(BusIdle), 8'(Request == 4'b0 && m_owner < 0));
      chk({tag, ".timeout"}, 8'(Timeout), 8'(m_to));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge GlobalClock);
      #1;
      check(tag);
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      #2;
      model_reset();
      check("reset_async");
      Reset = 1'b0;
   endtask

   initial begin
      logic [3:0] r;
      Reset = 1'b1;
      ClockEnable = 1'b1;
      Request = 4'b0;
      model_reset();
      #3;
      check("reset");
      @(posedge GlobalClock);
      #1;
      check("reset_hold");
      Reset = 1'b0;
      repeat (2) tick("post_reset");
      Request = 4'b0001;
      tick("pre_reset_grant");
      #2;
      Reset = 1'b1;
      Request = 4'b0;
      model_reset();
      #1;
      check("reset_mid_grant");
      chk("reset_mid_grant_idle", 8'(BusIdle), 8'd1);
      Reset = 1'b0;
      tick("idle_after_reset");
      Request = 4'b0100;
      tick("single_grant");
      chk("single_grant_id", 8'(GrantId), 8'd2);
      repeat (3) tick("single_hold");
      Request = 4'b0;
      tick("single_gap");
      tick("single_idle");
      pulse_reset();
      Request = 4'b1111;
      tick("rr_first");
      chk("rr_first_id", 8'(GrantId), 8'd0);
      for (int n = 0; n < 4; n++) begin
         tick("rr_hold");
         Request = 4'b1111 & ~4'(1 << m_gid);
         tick("rr_gap");
         chk("rr_gap_zero", 8'(Grant), 8'd0);
         Request = 4'b1111;
         tick("rr_next");
         chk("rr_order", 8'(GrantId), 8'((n + 1) % 4));
      end
      ClockEnable = 1'b0;
      Request = 4'b1110;
      repeat (3) tick("freeze_hold");
      chk("freeze_grant", 8'(Grant), 8'd1);
      ClockEnable = 1'b1;
      tick("freeze_release");
      pulse_reset();
      Request = 4'b0011;
      repeat (5) tick("tmo_run");
      chk("tmo_pulse", 8'(Timeout), 8'(TMO_ON));
      tick("tmo_next");
      chk("tmo_next_owner", 8'(GrantId), 8'(TMO_ON));
      tick("tmo_clear");
      pulse_reset();
      Request = 4'b1000;
      tick("wrap_own3");
      Request = 4'b0;
      tick("wrap_gap");
      Request = 4'b1001;
      tick("wrap_grant");
      chk("wrap_id", 8'(GrantId), 8'd0);
      for (int i = 0; i < 400; i++) begin
         ClockEnable = ($urandom_range(0, 9) != 0);
         r = 4'($urandom_range(0, 15));
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
         Request = ~r;
         #2;
         Request = r;
         if ($urandom_range(0, 59) == 0) pulse_reset();
         tick("random");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
